// File: rtl/sa_pkg.sv
// Shared types and constants for the QR systolic array controllers.
// Data words are raw IEEE-754 single bit patterns; nothing here interprets them.
package sa_pkg;

  localparam int DW = 32;
  localparam logic [DW-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Counter width for a range of n values, never narrower than one bit
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Block input stream (valid/ready) plus the skewed column feed towards the array.
// master = stream source / feed sink, slave = the feed controller.
interface systolic_feed_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = sa_pkg::DW
);

  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [N*DW-1:0] x_bus;
  logic [N-1:0]    x_vld;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  x_bus,
    input  x_vld
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output x_bus,
    output x_vld
  );

endinterface

// File: rtl/skew_buffer.sv
// M x N word store, one (row,col) write port and N combinational diagonal read ports.
// Column j reads row rd_t-j; rows outside 0..M-1 read back as +0.0 with rd_vld[j]=0.
module skew_buffer
  import sa_pkg::*;
#(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int DW = sa_pkg::DW
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [cw(M)-1:0]        wr_row,
  input  logic [cw(N)-1:0]        wr_col,
  input  logic [DW-1:0]           wr_dat,
  input  logic [cw(M+N)-1:0]      rd_t,
  output logic [N*DW-1:0]         rd_bus,
  output logic [N-1:0]            rd_vld
);

  localparam int RW = cw(M);

  logic [DW-1:0] mem [M][N];

  // Contents are deliberately not reset: every word is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row][wr_col] <= wr_dat;
    end
  end

  always_comb begin
    int row;
    row    = 0;
    rd_bus = '0;
    rd_vld = '0;
    for (int j = 0; j < N; j++) begin
      row = int'(rd_t) - j;
      rd_bus[j*DW +: DW] = DW'(FP_ZERO);
      if (row >= 0 && row < M) begin
        rd_bus[j*DW +: DW] = mem[row[RW-1:0]][j];
        rd_vld[j]          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Buffers one M x N block, replays it diagonally skewed into N column feeds, drains, pulses done.
// Last load beat -> first feed word in 2 cycles; in_ready is high only while loading.
module systolic_feed_ctrl
  import sa_pkg::*;
#(
  parameter int N         = 4,
  parameter int M         = 4,
  parameter int DW        = sa_pkg::DW,
  parameter int DRAIN_CYC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  systolic_feed_ctrl_if.slave  bus,
  output logic                 arr_clr,
  output logic                 busy,
  output logic                 done
);

  localparam int RW     = cw(M);
  localparam int CW     = cw(N);
  localparam int TW     = cw(M + N);
  localparam int DCW    = cw(DRAIN_CYC + 1);
  localparam int T_LAST = M + N - 1;

  state_t          state, nxt;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [TW-1:0]   t;
  logic [DCW-1:0]  dcnt;
  logic            beat, last_beat;
  logic [N*DW-1:0] rd_bus, x_bus_q;
  logic [N-1:0]    rd_vld, x_vld_q;

  assign beat      = (state == LOAD) && bus.in_valid;
  assign last_beat = beat && (row == RW'(M - 1)) && (col == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    if (last_beat) nxt = CLR;
      CLR:     nxt = FEED;
      FEED:    if (t == TW'(T_LAST)) nxt = DRAIN;
      DRAIN:   if (dcnt == DCW'(DRAIN_CYC - 1)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == LOAD);
    arr_clr      = (state == CLR);
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

  // t runs one ahead of the word on x_bus: the output register is loaded from t
  // on the edge that enters (or stays in) FEED, so FEED's first cycle already shows t=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row  <= '0;
      col  <= '0;
      t    <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          row  <= '0;
          col  <= '0;
          t    <= '0;
          dcnt <= '0;
        end
        LOAD: begin
          if (beat) begin
            if (col == CW'(N - 1)) begin
              col <= '0;
              row <= (row == RW'(M - 1)) ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        CLR, FEED: t <= (nxt == FEED) ? t + TW'(1) : '0;
        DRAIN:     dcnt <= dcnt + DCW'(1);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_bus_q <= '0;
      x_vld_q <= '0;
    end else if (nxt == FEED) begin
      x_bus_q <= rd_bus;
      x_vld_q <= rd_vld;
    end else begin
      x_bus_q <= '0;
      x_vld_q <= '0;
    end
  end

  assign bus.x_bus = x_bus_q;
  assign bus.x_vld = x_vld_q;

  skew_buffer #(
    .N  (N),
    .M  (M),
    .DW (DW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (beat),
    .wr_row (row),
    .wr_col (col),
    .wr_dat (bus.in_data),
    .rd_t   (t),
    .rd_bus (rd_bus),
    .rd_vld (rd_vld)
  );

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: a 2x2/DRAIN 3 instance and a 4x4/DRAIN 8 instance,
// each block checked cycle by cycle against the diagonal-skew rule A[t-j][j].
module tb_systolic_feed_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start2, start4;
  logic clr2, clr4, busy2, busy4, done2, done4;

  systolic_feed_ctrl_if #(.N(2), .DW(32)) if2 ();
  systolic_feed_ctrl_if #(.N(4), .DW(32)) if4 ();

  systolic_feed_ctrl #(.N(2), .M(2), .DW(32), .DRAIN_CYC(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .bus(if2),
    .arr_clr(clr2), .busy(busy2), .done(done2)
  );

  systolic_feed_ctrl #(.N(4), .M(4), .DW(32), .DRAIN_CYC(8)) u4 (
    .clk(clk), .rst(rst), .start(start4), .bus(if4),
    .arr_clr(clr4), .busy(busy4), .done(done4)
  );

  int checks = 0;
  int errors = 0;
  int ndone2 = 0;
  int ndone4 = 0;
  bit sel;
  int nn, mm, dd;
  logic [31:0] A [$];

  logic [127:0] o_bus, o_vld, o_rdy, o_clr, o_busy, o_done;

  always_comb begin
    if (sel) begin
      o_bus  = if4.x_bus;
      o_vld  = 128'(if4.x_vld);
      o_rdy  = 128'(if4.in_ready);
      o_clr  = 128'(clr4);
      o_busy = 128'(busy4);
      o_done = 128'(done4);
    end else begin
      o_bus  = 128'(if2.x_bus);
      o_vld  = 128'(if2.x_vld);
      o_rdy  = 128'(if2.in_ready);
      o_clr  = 128'(clr2);
      o_busy = 128'(busy2);
      o_done = 128'(done2);
    end
  end

  always @(negedge clk) begin
    if (done2) ndone2++;
    if (done4) ndone4++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_bus"},  o_bus,  128'd0);
    chk({p, "_vld"},  o_vld,  128'd0);
    chk({p, "_rdy"},  o_rdy,  128'd0);
    chk({p, "_clr"},  o_clr,  128'd0);
    chk({p, "_busy"}, o_busy, 128'd0);
    chk({p, "_done"}, o_done, 128'd0);
  endtask

  // Reference: column j carries row t-j of the block whenever that row exists
  function automatic logic [127:0] exp_bus(input int t);
    logic [127:0] b;
    b = '0;
    for (int j = 0; j < nn; j++)
      if (t - j >= 0 && t - j < mm) b[j*32 +: 32] = A[(t - j) * nn + j];
    return b;
  endfunction

  function automatic logic [127:0] exp_vld(input int t);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < nn; j++)
      if (t - j >= 0 && t - j < mm) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] f2b(input int n);
    int e;
    logic [31:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n - (1 << e)) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic drive(input logic st, input logic v, input logic [31:0] d);
    start2        = sel ? 1'b0 : st;
    if2.in_valid  = sel ? 1'b0 : v;
    if2.in_data   = d;
    start4        = sel ? st : 1'b0;
    if4.in_valid  = sel ? v : 1'b0;
    if4.in_data   = d;
  endtask

  task automatic set_dut(input bit s);
    sel = s;
    nn  = s ? 4 : 2;
    mm  = nn;
    dd  = s ? 8 : 3;
  endtask

  task automatic rand_block();
    A.delete();
    for (int i = 0; i < mm * nn; i++) A.push_back($urandom);
  endtask

  // One full block: load (optionally with valid gaps), CLR, FEED, DRAIN, DONE.
  // rst_at >= 0 pulls reset at that FEED step and abandons the block.
  task automatic run_block(input bit gaps, input bit inj, input int rst_at);
    int idx, dn0, dn1;
    bit v, lastv;
    dn0 = sel ? ndone4 : ndone2;
    @(negedge clk);
    chk("idle_rdy", o_rdy, 128'd0);
    chk("idle_busy", o_busy, 128'd0);
    drive(1'b1, 1'b1, $urandom);
    @(negedge clk);
    chk("load_busy", o_busy, 128'd1);
    idx   = 0;
    lastv = 1'b0;
    while (idx < mm * nn) begin
      chk("load_rdy", o_rdy, 128'd1);
      v = gaps ? !lastv : 1'b1;
      lastv = v;
      drive(1'b0, v, v ? A[idx] : $urandom);
      @(negedge clk);
      if (v) idx++;
    end
    drive(1'b0, 1'b0, 32'd0);
    chk("clr_pulse", o_clr, 128'd1);
    chk("clr_rdy", o_rdy, 128'd0);
    chk("clr_bus", o_bus, 128'd0);
    chk("clr_vld", o_vld, 128'd0);
    for (int t = 0; t < nn + mm - 1; t++) begin
      @(negedge clk);
      if (t == rst_at) begin
        drive(1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        #2 rst = 1'b1;
        return;
      end
      chk($sformatf("feed_bus_t%0d", t), o_bus, exp_bus(t));
      chk($sformatf("feed_vld_t%0d", t), o_vld, exp_vld(t));
      chk("feed_clr", o_clr, 128'd0);
      chk("feed_busy", o_busy, 128'd1);
      drive((inj && t == 1) ? 1'b1 : 1'b0, 1'b0, 32'd0);
    end
    for (int k = 0; k < dd; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0);
      chk("drain_bus", o_bus, 128'd0);
      chk("drain_vld", o_vld, 128'd0);
      chk("drain_done", o_done, 128'd0);
      chk("drain_busy", o_busy, 128'd1);
    end
    @(negedge clk);
    chk("done_pulse", o_done, 128'd1);
    chk("done_busy", o_busy, 128'd1);
    drive(inj, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0);
    chk("post_done", o_done, 128'd0);
    chk("post_busy", o_busy, 128'd0);
    chk("post_rdy", o_rdy, 128'd0);
    @(negedge clk);
    chk("no_restart", o_busy, 128'd0);
    dn1 = sel ? ndone4 : ndone2;
    chk("one_done", 128'(dn1 - dn0), 128'd1);
  endtask

  initial begin
    int d0;
    rst          = 1'b0;
    set_dut(1'b0);
    start2       = 1'b1;
    start4       = 1'b1;
    if2.in_valid = 1'b1;
    if4.in_valid = 1'b1;
    if2.in_data  = 32'hdead_beef;
    if4.in_data  = 32'hdead_beef;
    #2;
    chk_all_zero("rst2");
    set_dut(1'b1);
    #1;
    chk_all_zero("rst4");
    #9;
    chk_all_zero("rst4_start");
    set_dut(1'b0);
    #1;
    chk_all_zero("rst2_start");
    #3;
    drive(1'b0, 1'b0, 32'd0);
    rst = 1'b1;

    // Directed 2x2 block
    A = {32'h4090_0000, 32'hc020_0000, 32'h4000_0000, 32'h4120_0000};
    run_block(1'b0, 1'b0, -1);
    run_block(1'b1, 1'b0, -1);

    // Start pulses in FEED and DONE are ignored
    rand_block();
    run_block(1'b0, 1'b1, -1);

    // Reset mid-FEED, then a clean block
    rand_block();
    d0 = ndone2;
    run_block(1'b0, 1'b0, 1);
    repeat (4) @(negedge clk);
    chk("rst_no_done", 128'(ndone2 - d0), 128'd0);
    chk("rst_idle", o_busy, 128'd0);
    rand_block();
    run_block(1'b1, 1'b0, -1);

    for (int i = 0; i < 3; i++) begin
      rand_block();
      run_block(1'(i % 2), 1'(i == 1), -1);
    end

    // 4x4 instance: words 1.0 .. 16.0, then a random block
    set_dut(1'b1);
    A.delete();
    for (int i = 1; i <= 16; i++) A.push_back(f2b(i));
    run_block(1'b0, 1'b0, -1);
    rand_block();
    run_block(1'b1, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
